btb_predictor: RTL and testbench

- Parametrised branch target buffer with a 2-bit direction predictor for the redirection pipeline.
- The IF-stage lookup is combinational. It supplies the predicted next PC alongside the PC update logic.
- Updates use resolved branch/jump outcomes from EX.
- The block generates the mispredict redirect and keeps saturating performance counters.

---
 rtl/btb_predictor_if.sv | 43 ++++
 rtl/btb_predictor.sv | 199 +++++++++++++++++++
 tb/tb_btb_predictor.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_predictor_if.sv
// Bus between the fetch/execute pipeline and the branch target buffer.
// The pipeline side (master) drives the fetch PC and the resolved outcome.
// The predictor side (slave) returns the prediction, the redirect and the statistics.
interface btb_predictor_if #(
    parameter int CNT_W = 16
);
    // IF-stage lookup
    logic [31:0]      IF_PC;
    logic             Pred_Hit;
    logic             Pred_Taken;
    logic [31:0]      Pred_Target;
    logic [31:0]      PC_Next_IF;

    // EX-stage resolution
    logic             EX_Valid;
    logic [31:0]      EX_PC;
    logic             EX_Taken;
    logic [31:0]      EX_Target;
    logic             EX_PredTaken;
    logic [31:0]      EX_PredTarget;
    logic             Redirect;
    logic [31:0]      Redirect_PC;

    // Performance counters
    logic [CNT_W-1:0] Stat_Lookups;
    logic [CNT_W-1:0] Stat_Mispredicts;

    modport master (
        output IF_PC,
        output EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken, EX_PredTarget,
        input  Pred_Hit, Pred_Taken, Pred_Target, PC_Next_IF,
        input  Redirect, Redirect_PC,
        input  Stat_Lookups, Stat_Mispredicts
    );

    modport slave (
        input  IF_PC,
        input  EX_Valid, EX_PC, EX_Taken, EX_Target, EX_PredTaken, EX_PredTarget,
        output Pred_Hit, Pred_Taken, Pred_Target, PC_Next_IF,
        output Redirect, Redirect_PC,
        output Stat_Lookups, Stat_Mispredicts
    );
endinterface

// File: rtl/btb_predictor.sv
// Fully-associative branch target buffer with 2-bit saturating direction
// counters, true-LRU replacement, mispredict redirect and saturating
// performance counters. The fetch lookup is zero-latency; updates from the
// resolved EX outcome land on the next rising clock edge.
module btb_predictor #(
    parameter int ENTRIES = 8,
    parameter int AGE_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic           CLK,
    input  logic           RST,
    btb_predictor_if.slave bus
);

    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0] STAT_MAX = '1;

    // 2-bit direction counter, saturating at strongly-taken
    function automatic logic [1:0] ctr_inc_sat(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    // 2-bit direction counter, saturating at strongly-not-taken
    function automatic logic [1:0] ctr_dec_sat(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Statistics counter that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] stat_inc_sat(input logic [CNT_W-1:0] c,
                                                      input logic             en);
        return (en && (c != STAT_MAX)) ? c + CNT_W'(1) : c;
    endfunction

    // Table state
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [29:0]      tag_q    [ENTRIES];
    logic [29:0]      tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [AGE_W-1:0] age_q    [ENTRIES];
    logic [AGE_W-1:0] age_d    [ENTRIES];

    logic [CNT_W-1:0] lookups_q, lookups_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    // Fetch-side lookup results
    logic             lk_hit;
    logic             lk_ctr_msb;
    logic [31:0]      lk_target;

    // Execute-side match and replacement choice
    logic             ex_hit;
    logic [AGE_W-1:0] ex_idx;
    logic             inv_found;
    logic [AGE_W-1:0] victim_idx;
    logic             touch_en;
    logic [AGE_W-1:0] touch_idx;
    logic [AGE_W-1:0] touch_age;

    logic             redirect_w;

    // Fetch lookup: tags are unique, so at most one entry drives the result
    always_comb begin
        lk_hit     = 1'b0;
        lk_ctr_msb = 1'b0;
        lk_target  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.IF_PC[31:2])) begin
                lk_hit     = 1'b1;
                lk_ctr_msb = ctr_q[i][1];
                lk_target  = target_q[i];
            end
        end
    end

    // Execute match: independent of the fetch port so both can hit different entries
    always_comb begin
        ex_hit = 1'b0;
        ex_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == bus.EX_PC[31:2])) begin
                ex_hit = 1'b1;
                ex_idx = AGE_W'(i);
            end
        end
    end

    // Victim selection: fill empty slots lowest-first, otherwise evict the oldest entry
    always_comb begin
        inv_found  = 1'b0;
        victim_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!valid_q[i] && !inv_found) begin
                inv_found  = 1'b1;
                victim_idx = AGE_W'(i);
            end
        end
        if (!inv_found) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (age_q[i] == AGE_MAX) begin
                    victim_idx = AGE_W'(i);
                end
            end
        end
    end

    // Next table state: counter/target update or allocation, then the LRU touch
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            ctr_d[i]    = ctr_q[i];
            age_d[i]    = age_q[i];
        end
        touch_en  = 1'b0;
        touch_idx = ex_idx;

        if (bus.EX_Valid) begin
            if (ex_hit) begin
                touch_en = 1'b1;
                if (bus.EX_Taken) begin
                    ctr_d[ex_idx]    = ctr_inc_sat(ctr_q[ex_idx]);
                    // Always refresh the target so indirect jumps follow their latest destination
                    target_d[ex_idx] = bus.EX_Target;
                end else begin
                    ctr_d[ex_idx]    = ctr_dec_sat(ctr_q[ex_idx]);
                end
            end else if (bus.EX_Taken) begin
                touch_en              = 1'b1;
                touch_idx             = victim_idx;
                valid_d[victim_idx]   = 1'b1;
                tag_d[victim_idx]     = bus.EX_PC[31:2];
                target_d[victim_idx]  = bus.EX_Target;
                ctr_d[victim_idx]     = 2'b10;
            end
        end

        touch_age = age_q[touch_idx];
        if (touch_en) begin
            // Move the touched entry to MRU; only entries younger than it age by one
            for (int i = 0; i < ENTRIES; i++) begin
                if (AGE_W'(i) == touch_idx) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + AGE_W'(1);
                end
            end
        end
    end

    // Mispredict: wrong direction, or right direction with a stale target
    assign redirect_w = bus.EX_Valid &
                        ((bus.EX_Taken != bus.EX_PredTaken) |
                         (bus.EX_Taken & bus.EX_PredTaken &
                          (bus.EX_Target != bus.EX_PredTarget)));

    assign lookups_d = stat_inc_sat(lookups_q, bus.EX_Valid);
    assign mispred_d = stat_inc_sat(mispred_q, redirect_w & ~RST);

    // Table and statistics registers; reset restores the identity age permutation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
                age_q[i]    <= AGE_W'(i);
            end
            lookups_q <= '0;
            mispred_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                ctr_q[i]    <= ctr_d[i];
                age_q[i]    <= age_d[i];
            end
            lookups_q <= lookups_d;
            mispred_q <= mispred_d;
        end
    end

    // Outputs are forced quiet while reset is held so no stale prediction escapes
    assign bus.Pred_Hit         = lk_hit & ~RST;
    assign bus.Pred_Taken       = lk_hit & lk_ctr_msb & ~RST;
    assign bus.Pred_Target      = lk_target & {32{lk_hit & ~RST}};
    assign bus.PC_Next_IF       = bus.Pred_Taken ? bus.Pred_Target : bus.IF_PC + 32'd4;
    assign bus.Redirect         = redirect_w & ~RST;
    assign bus.Redirect_PC      = bus.EX_Taken ? bus.EX_Target : bus.EX_PC + 32'd4;
    assign bus.Stat_Lookups     = lookups_q;
    assign bus.Stat_Mispredicts = mispred_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: every driven cycle pushes the expected
// outputs (from a behavioural model with an MRU-ordered list for LRU) and
// scenario-specific constants; they are popped and compared once settled.
module tb_btb_predictor;

    localparam int ENTRIES  = 8;
    localparam int AGE_W    = 3;
    localparam int CNT_W    = 4;
    localparam int STAT_MAX = (1 << CNT_W) - 1;

    localparam int SEL_HIT   = 0;
    localparam int SEL_TAKEN = 1;
    localparam int SEL_TGT   = 2;
    localparam int SEL_NEXT  = 3;
    localparam int SEL_REDIR = 4;
    localparam int SEL_RPC   = 5;
    localparam int SEL_LK    = 6;
    localparam int SEL_MP    = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    btb_predictor_if #(.CNT_W(CNT_W)) bus ();

    btb_predictor #(
        .ENTRIES (ENTRIES),
        .AGE_W   (AGE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    string       sb_tag [$];
    int          sb_sel [$];
    logic [31:0] sb_val [$];

    // Behavioural model
    logic        m_valid [ENTRIES];
    logic [29:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_lru   [$];       // front = most recently used
    int          m_lk;
    int          m_mp;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_HIT:   return {31'b0, bus.Pred_Hit};
            SEL_TAKEN: return {31'b0, bus.Pred_Taken};
            SEL_TGT:   return bus.Pred_Target;
            SEL_NEXT:  return bus.PC_Next_IF;
            SEL_REDIR: return {31'b0, bus.Redirect};
            SEL_RPC:   return bus.Redirect_PC;
            SEL_LK:    return 32'(bus.Stat_Lookups);
            SEL_MP:    return 32'(bus.Stat_Mispredicts);
            default:   return 32'hxxxxxxxx;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input logic [31:0] val);
        sb_tag.push_back(tag);
        sb_sel.push_back(sel);
        sb_val.push_back(val);
    endtask

    task automatic drain();
        string       t;
        int          s;
        logic [31:0] v;
        while (sb_tag.size() > 0) begin
            t = sb_tag.pop_front();
            s = sb_sel.pop_front();
            v = sb_val.pop_front();
            check_eq(t, observe(s), v);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 0;
        end
        m_lru.delete();
        for (int i = 0; i < ENTRIES; i++) m_lru.push_back(i);
        m_lk = 0;
        m_mp = 0;
    endtask

    function automatic int m_find(input logic [31:0] pc);
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && (m_tag[i] == pc[31:2])) return i;
        return -1;
    endfunction

    task automatic m_touch(input int k);
        int pos;
        pos = -1;
        for (int p = 0; p < m_lru.size(); p++)
            if (m_lru[p] == k) pos = p;
        if (pos >= 0) m_lru.delete(pos);
        m_lru.push_front(k);
    endtask

    // One clock cycle: drive, push model expectations, compare, then advance the model at the edge
    task automatic step(input logic [31:0] ifpc, input logic v, input logic [31:0] pc,
                        input logic t, input logic [31:0] tgt,
                        input logic pt, input logic [31:0] ptgt);
        int          k;
        logic        ptaken;
        logic [31:0] ptarget;
        logic        redir;
        bus.IF_PC         = ifpc;
        bus.EX_Valid      = v;
        bus.EX_PC         = pc;
        bus.EX_Taken      = t;
        bus.EX_Target     = tgt;
        bus.EX_PredTaken  = pt;
        bus.EX_PredTarget = ptgt;

        k       = m_find(ifpc);
        ptaken  = (k >= 0) && (m_ctr[k] >= 2);
        ptarget = (k >= 0) ? m_tgt[k] : 32'h0;
        redir   = v && ((t != pt) || (t && pt && (tgt != ptgt)));

        expect_v("pred_hit",    SEL_HIT,   (k >= 0) ? 32'd1 : 32'd0);
        expect_v("pred_taken",  SEL_TAKEN, ptaken ? 32'd1 : 32'd0);
        expect_v("pred_target", SEL_TGT,   ptarget);
        expect_v("pc_next_if",  SEL_NEXT,  ptaken ? ptarget : ifpc + 32'd4);
        expect_v("redirect",    SEL_REDIR, redir ? 32'd1 : 32'd0);
        if (v) expect_v("redirect_pc", SEL_RPC, t ? tgt : pc + 32'd4);
        expect_v("stat_lookups",     SEL_LK, 32'(m_lk));
        expect_v("stat_mispredicts", SEL_MP, 32'(m_mp));

        #1;
        drain();
        @(posedge CLK);

        if (v) begin
            if (m_lk < STAT_MAX) m_lk++;
            if (redir && (m_mp < STAT_MAX)) m_mp++;
            k = m_find(pc);
            if (k >= 0) begin
                if (t) begin
                    if (m_ctr[k] < 3) m_ctr[k]++;
                    m_tgt[k] = tgt;
                end else if (m_ctr[k] > 0) begin
                    m_ctr[k]--;
                end
                m_touch(k);
            end else if (t) begin
                for (int i = ENTRIES - 1; i >= 0; i--)
                    if (!m_valid[i]) k = i;
                if (k < 0) k = m_lru[m_lru.size() - 1];
                m_valid[k] = 1'b1;
                m_tag[k]   = pc[31:2];
                m_tgt[k]   = tgt;
                m_ctr[k]   = 2;
                m_touch(k);
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle(input logic [31:0] ifpc);
        step(ifpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Resolve a branch with the prediction it would have carried from fetch
    task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        int          k;
        logic        pt;
        logic [31:0] ptgt;
        k    = m_find(pc);
        pt   = (k >= 0) && (m_ctr[k] >= 2);
        ptgt = (k >= 0) ? m_tgt[k] : 32'h0;
        step(pc, 1'b1, pc, t, tgt, pt, ptgt);
    endtask

    task automatic pulse_reset();
        bus.EX_Valid = 1'b0;
        RST = 1'b1;
        #1;
        m_reset();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        bus.IF_PC         = 32'h0;
        bus.EX_Valid      = 1'b0;
        bus.EX_PC         = 32'h0;
        bus.EX_Taken      = 1'b0;
        bus.EX_Target     = 32'h0;
        bus.EX_PredTaken  = 1'b0;
        bus.EX_PredTarget = 32'h0;
        m_reset();
        @(negedge CLK);

        // Outputs while reset is held, with a mismatching EX resolution present
        bus.IF_PC     = 32'h0040_0000;
        bus.EX_Valid  = 1'b1;
        bus.EX_PC     = 32'h0040_0010;
        bus.EX_Taken  = 1'b1;
        bus.EX_Target = 32'h0040_0040;
        #1;
        expect_v("rst_hit",      SEL_HIT,   32'd0);
        expect_v("rst_taken",    SEL_TAKEN, 32'd0);
        expect_v("rst_target",   SEL_TGT,   32'd0);
        expect_v("rst_next",     SEL_NEXT,  32'h0040_0004);
        expect_v("rst_redirect", SEL_REDIR, 32'd0);
        expect_v("rst_lookups",  SEL_LK,    32'd0);
        expect_v("rst_mispred",  SEL_MP,    32'd0);
        drain();
        bus.EX_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;

        // First taken branch misses, redirects and allocates
        expect_v("t1_hit",   SEL_HIT,   32'd0);
        expect_v("t1_next",  SEL_NEXT,  32'h0040_0004);
        expect_v("t1_redir", SEL_REDIR, 32'd1);
        expect_v("t1_rpc",   SEL_RPC,   32'h0040_0040);
        step(32'h0040_0000, 1'b1, 32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0);
        expect_v("t1_taken_after", SEL_TAKEN, 32'd1);
        expect_v("t1_next_after",  SEL_NEXT,  32'h0040_0040);
        idle(32'h0040_0010);

        // Counter walk: 2 -> 1 -> 0, then up to 3 and held there
        expect_v("ctr_nt1_redir", SEL_REDIR, 32'd1);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040);
        expect_v("ctr_nt2_redir", SEL_REDIR, 32'd0);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040);
        expect_v("ctr0_hit",   SEL_HIT,   32'd1);
        expect_v("ctr0_taken", SEL_TAKEN, 32'd0);
        idle(32'h0040_0010);
        for (int i = 0; i < 4; i++) resolve(32'h0040_0010, 1'b1, 32'h0040_0040);
        resolve(32'h0040_0010, 1'b0, 32'h0040_0040);
        expect_v("ctr_sat_taken", SEL_TAKEN, 32'd1);
        idle(32'h0040_0010);
        expect_v("unaligned_hit", SEL_HIT, 32'd1);
        idle(32'h0040_0013);

        // Indirect jump whose target changes
        resolve(32'h0040_0080, 1'b1, 32'h0040_1000);
        expect_v("jr_redir", SEL_REDIR, 32'd1);
        expect_v("jr_rpc",   SEL_RPC,   32'h0040_2000);
        resolve(32'h0040_0080, 1'b1, 32'h0040_2000);
        expect_v("jr_target", SEL_TGT,  32'h0040_2000);
        expect_v("jr_next",   SEL_NEXT, 32'h0040_2000);
        idle(32'h0040_0080);

        // PC+4 wraps at the top of the address space
        expect_v("wrap_next", SEL_NEXT, 32'h0);
        expect_v("wrap_rpc",  SEL_RPC,  32'h0);
        step(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);

        // LRU replacement: fill A..H, refresh A, allocate I -> B leaves
        pulse_reset();
        for (int i = 0; i < ENTRIES; i++)
            resolve(32'h0050_0000 + 32'(i * 16), 1'b1, 32'h0060_0000 + 32'(i * 256));
        resolve(32'h0050_0000, 1'b1, 32'h0060_0000);
        resolve(32'h0050_0100, 1'b1, 32'h0060_F000);
        expect_v("lru_b_evicted", SEL_HIT, 32'd0);
        idle(32'h0050_0010);
        expect_v("lru_a_kept", SEL_HIT, 32'd1);
        idle(32'h0050_0000);
        expect_v("lru_i_hit", SEL_TGT, 32'h0060_F000);
        idle(32'h0050_0100);
        expect_v("lru_c_kept", SEL_HIT, 32'd1);
        idle(32'h0050_0020);

        // Saturating statistics
        pulse_reset();
        for (int i = 0; i < 20; i++)
            step(32'h0080_0000, 1'b1, 32'h0090_0000 + 32'(i * 4), 1'b0, 32'h0, 1'b1, 32'h0000_1234);
        expect_v("stat_lk_sat", SEL_LK, 32'd15);
        expect_v("stat_mp_sat", SEL_MP, 32'd15);
        idle(32'h0080_0000);

        // Asynchronous reset between edges clears everything at once
        for (int i = 0; i < 3; i++)
            resolve(32'h00A0_0000 + 32'(i * 16), 1'b1, 32'h00B0_0000 + 32'(i * 16));
        #2;
        RST = 1'b1;
        bus.IF_PC         = 32'h00A0_0000;
        bus.EX_Valid      = 1'b1;
        bus.EX_PC         = 32'h00A0_0010;
        bus.EX_Taken      = 1'b1;
        bus.EX_Target     = 32'h00C0_0000;
        bus.EX_PredTaken  = 1'b0;
        bus.EX_PredTarget = 32'h0;
        #1;
        expect_v("arst_hit",      SEL_HIT,   32'd0);
        expect_v("arst_taken",    SEL_TAKEN, 32'd0);
        expect_v("arst_next",     SEL_NEXT,  32'h00A0_0004);
        expect_v("arst_redirect", SEL_REDIR, 32'd0);
        expect_v("arst_lookups",  SEL_LK,    32'd0);
        expect_v("arst_mispred",  SEL_MP,    32'd0);
        drain();
        bus.IF_PC = 32'h00A0_0020;
        #1;
        expect_v("arst_hit_c", SEL_HIT, 32'd0);
        drain();
        bus.EX_Valid = 1'b0;
        m_reset();
        @(negedge CLK);
        RST = 1'b0;
        expect_v("post_arst_hit", SEL_HIT, 32'd0);
        idle(32'h00A0_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
